// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU types for the TLBs and the page-table walker.
package mmu_pkg;

    localparam int PAGE_SHIFT = 12;

    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } tlb_perm_bits;

    typedef enum logic [1:0] {
        ACC_LOAD  = 2'd0,
        ACC_STORE = 2'd1,
        ACC_FETCH = 2'd2
    } acc_e;

    typedef enum logic {
        TLB_IDLE,
        TLB_WALK
    } tlb_state_e;

    // Access type 3 falls through to the load check.
    function automatic logic perm_ok(tlb_perm_bits p, logic [1:0] acc);
        return p.v && (acc_e'(acc) == ACC_STORE ? p.w :
                       acc_e'(acc) == ACC_FETCH ? p.x : p.r);
    endfunction

endpackage

// File: rtl/tlb_cam.sv
// tlb_cam: fully associative entry array with one-hot vpn match and a single write port.
module tlb_cam
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [51:0]      wvpn_i,
    input  logic [51:0]      wppn_i,
    input  logic [7:0]       wperm_i,
    input  logic [51:0]      lvpn_i,
    output logic             hit_o,
    output logic [51:0]      ppn_o,
    output logic [7:0]       perm_o
);

    logic [ENTRIES-1:0] valid_q;
    logic [51:0]        vpn_q  [ENTRIES];
    logic [51:0]        ppn_q  [ENTRIES];
    logic [7:0]         perm_q [ENTRIES];
    logic [ENTRIES-1:0] hit_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        valid_q <= '0;
        else if (flush_i) valid_q <= '0;
        else if (we_i)    valid_q[widx_i] <= 1'b1;
    end

    // Payload needs no reset: it is only ever observed through a valid bit.
    always_ff @(posedge clk) begin
        if (we_i && !flush_i) begin
            vpn_q[widx_i]  <= wvpn_i;
            ppn_q[widx_i]  <= wppn_i;
            perm_q[widx_i] <= wperm_i;
        end
    end

    // Hits are one-hot, so an OR-reduction acts as the data mux.
    always_comb begin
        hit_vec = '0;
        ppn_o   = '0;
        perm_o  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec[i] = valid_q[i] && vpn_q[i] == lvpn_i;
            ppn_o      = ppn_o | (hit_vec[i] ? ppn_q[i] : 52'd0);
            perm_o     = perm_o | (hit_vec[i] ? perm_q[i] : 8'd0);
        end
        hit_o = |hit_vec;
    end

endmodule

// File: rtl/tlb.sv
// tlb: fully associative TLB with combinational hit path, fault record and miss walk to the shared walker.
module tlb
    import mmu_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid,
    input  logic [63:0] lookup_addr,
    input  logic [1:0]  lookup_acc,
    output logic        resp_valid,
    output logic [63:0] resp_paddr,
    output logic        resp_fault,
    input  logic        flush,
    output logic        mmu_req_valid,
    output logic [63:0] mmu_req_addr,
    input  logic        mmu_resp_valid,
    input  logic [63:0] mmu_resp_addr,
    input  logic [7:0]  mmu_resp_perms
);

    tlb_state_e       state_q, state_d;
    logic [51:0]      miss_vpn_q, miss_vpn_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             discard_q, discard_d;
    logic             fr_valid_q, fr_valid_d;
    logic [51:0]      fr_vpn_q, fr_vpn_d;

    logic [51:0] lvpn;
    logic        cam_hit, hit, fr_hit, walk, take, keep, fill, miss;
    logic [51:0] cam_ppn;
    logic [7:0]  cam_perm;
    logic        unused_resp_offset;

    assign lvpn               = lookup_addr[63:PAGE_SHIFT];
    assign unused_resp_offset = ^mmu_resp_addr[PAGE_SHIFT-1:0];

    tlb_cam #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cam (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .we_i    (fill),
        .widx_i  (rr_q),
        .wvpn_i  (miss_vpn_q),
        .wppn_i  (mmu_resp_addr[63:PAGE_SHIFT]),
        .wperm_i (mmu_resp_perms),
        .lvpn_i  (lvpn),
        .hit_o   (cam_hit),
        .ppn_o   (cam_ppn),
        .perm_o  (cam_perm)
    );

    always_comb begin
        hit           = lookup_valid && cam_hit;
        fr_hit        = lookup_valid && fr_valid_q && fr_vpn_q == lvpn;
        walk          = state_q == TLB_WALK;
        miss          = !walk && lookup_valid && !hit && !fr_hit;
        take          = walk && mmu_resp_valid;
        keep          = take && !discard_q && !flush;
        fill          = keep && mmu_resp_perms[0];
        resp_valid    = hit || fr_hit;
        resp_fault    = fr_hit || (hit && !perm_ok(tlb_perm_bits'(cam_perm), lookup_acc));
        resp_paddr    = hit && !fr_hit ? {cam_ppn, lookup_addr[PAGE_SHIFT-1:0]} : 64'd0;
        mmu_req_valid = walk;
        mmu_req_addr  = walk ? {miss_vpn_q, {PAGE_SHIFT{1'b0}}} : 64'd0;
        state_d       = take ? TLB_IDLE : miss ? TLB_WALK : state_q;
        miss_vpn_d    = miss ? lvpn : miss_vpn_q;
        discard_d     = take ? 1'b0 : (walk && flush) ? 1'b1 : discard_q;
        rr_d          = fill ? rr_q + IDX_W'(1) : rr_q;
        fr_valid_d    = (keep && !mmu_resp_perms[0]) ? 1'b1 :
                        (flush || (lookup_valid && lvpn != fr_vpn_q)) ? 1'b0 : fr_valid_q;
        fr_vpn_d      = (keep && !mmu_resp_perms[0]) ? miss_vpn_q : fr_vpn_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TLB_IDLE;
            miss_vpn_q <= '0;
            rr_q       <= '0;
            discard_q  <= 1'b0;
            fr_valid_q <= 1'b0;
            fr_vpn_q   <= '0;
        end else begin
            state_q    <= state_d;
            miss_vpn_q <= miss_vpn_d;
            rr_q       <= rr_d;
            discard_q  <= discard_d;
            fr_valid_q <= fr_valid_d;
            fr_vpn_q   <= fr_vpn_d;
        end
    end

endmodule

// File: tb/tb_tlb.sv
// tb_tlb: directed and randomized checks of tlb against a queue-based reference model.
module tb_tlb;

    localparam int ENTRIES = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [63:0] lookup_addr = '0;
    logic [1:0]  lookup_acc = '0;
    logic        resp_valid, resp_fault, mmu_req_valid;
    logic [63:0] resp_paddr, mmu_req_addr;
    logic        flush = 1'b0;
    logic        mmu_resp_valid = 1'b0;
    logic [63:0] mmu_resp_addr = '0;
    logic [7:0]  mmu_resp_perms = '0;

    always #5 clk = ~clk;

    tlb #(.ENTRIES(ENTRIES)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_addr    (lookup_addr),
        .lookup_acc     (lookup_acc),
        .resp_valid     (resp_valid),
        .resp_paddr     (resp_paddr),
        .resp_fault     (resp_fault),
        .flush          (flush),
        .mmu_req_valid  (mmu_req_valid),
        .mmu_req_addr   (mmu_req_addr),
        .mmu_resp_valid (mmu_resp_valid),
        .mmu_resp_addr  (mmu_resp_addr),
        .mmu_resp_perms (mmu_resp_perms)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Round-robin replacement with flush-cleared valids behaves as evict-oldest.
    typedef struct {
        logic [51:0] vpn;
        logic [51:0] ppn;
        logic [7:0]  perm;
    } ent_t;

    ent_t        tq[$];
    bit          m_fr_v, m_walk, m_drop;
    logic [51:0] m_fr_vpn, m_miss;
    logic        o_rv, o_f, o_req;
    logic [63:0] o_pa, o_ra;

    task automatic model_reset();
        tq.delete();
        m_fr_v = 0;
        m_walk = 0;
        m_drop = 0;
        m_fr_vpn = '0;
        m_miss = '0;
    endtask

    task automatic cyc(input bit lv, input logic [63:0] a, input logic [1:0] acc, input bit fl,
                       input bit rv, input logic [63:0] ra, input logic [7:0] rp);
        logic [51:0] v;
        logic [51:0] pp;
        logic [7:0]  p;
        int          k;
        bit          hit, frh, ok, miss;
        ent_t        e;
        v = a[63:12];
        k = -1;
        foreach (tq[i]) if (tq[i].vpn == v) k = i;
        hit = lv && k >= 0;
        p = '0;
        pp = '0;
        if (hit) begin
            p = tq[k].perm;
            pp = tq[k].ppn;
        end
        frh = lv && m_fr_v && m_fr_vpn == v;
        ok = p[0] && (acc == 2'd1 ? p[2] : acc == 2'd2 ? p[3] : p[1]);
        lookup_valid = lv;
        lookup_addr = a;
        lookup_acc = acc;
        flush = fl;
        mmu_resp_valid = rv;
        mmu_resp_addr = ra;
        mmu_resp_perms = rp;
        #3;
        o_rv = resp_valid;
        o_f = resp_fault;
        o_pa = resp_paddr;
        o_req = mmu_req_valid;
        o_ra = mmu_req_addr;
        check("resp_valid", 64'(o_rv), 64'(hit || frh));
        check("resp_fault", 64'(o_f), 64'(frh || (hit && !ok)));
        check("resp_paddr", o_pa, (hit && !frh) ? {pp, a[11:0]} : 64'd0);
        check("req_valid", 64'(o_req), 64'(m_walk));
        check("req_addr", o_ra, m_walk ? {m_miss, 12'h000} : 64'd0);
        @(posedge clk);
        miss = lv && !hit && !frh;
        if (fl || (lv && v != m_fr_vpn)) m_fr_v = 0;
        if (fl) tq.delete();
        if (m_walk && rv) begin
            if (!m_drop && !fl) begin
                if (rp[0]) begin
                    if (tq.size() == ENTRIES) void'(tq.pop_front());
                    e.vpn = m_miss;
                    e.ppn = ra[63:12];
                    e.perm = rp;
                    tq.push_back(e);
                end else begin
                    m_fr_v = 1;
                    m_fr_vpn = m_miss;
                end
            end
            m_walk = 0;
            m_drop = 0;
        end else if (m_walk && fl) begin
            m_drop = 1;
        end else if (!m_walk && miss) begin
            m_walk = 1;
            m_miss = v;
        end
        #1;
    endtask

    function automatic logic [63:0] pg(input int n);
        logic [63:0] r;
        r = 64'(n) << 12;
        return r;
    endfunction

    initial begin
        model_reset();
        lookup_valid = 1'b1;
        lookup_addr = 64'h4000_1234;
        #3;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_fault", 64'(resp_fault), 64'd0);
        check("rst_resp_paddr", resp_paddr, 64'd0);
        check("rst_req_valid", 64'(mmu_req_valid), 64'd0);
        check("rst_req_addr", mmu_req_addr, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        cyc(1, 64'h4000_1234, 2'd0, 0, 0, 0, 0);
        check("cold_miss", 64'(o_rv), 64'd0);
        cyc(0, 0, 2'd0, 0, 1, 64'h8020_0000, 8'h0F);
        check("cold_req_addr", o_ra, 64'h4000_1000);
        cyc(1, 64'h4000_1234, 2'd0, 0, 0, 0, 0);
        check("cold_hit_paddr", o_pa, 64'h8020_0234);
        check("cold_hit_fault", 64'(o_f), 64'd0);

        cyc(1, 64'h5000_0010, 2'd1, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 0, 1, 64'h9000_0000, 8'h03);
        cyc(1, 64'h5000_0010, 2'd1, 0, 0, 0, 0);
        check("perm_store_valid", 64'(o_rv), 64'd1);
        check("perm_store_fault", 64'(o_f), 64'd1);
        cyc(1, 64'h5000_0010, 2'd0, 0, 0, 0, 0);
        check("perm_load_fault", 64'(o_f), 64'd0);
        check("perm_load_paddr", o_pa, 64'h9000_0010);

        cyc(1, 64'h6000_0000, 2'd0, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 0, 1, 64'hA000_0000, 8'h00);
        cyc(1, 64'h6000_0008, 2'd0, 0, 0, 0, 0);
        check("pf_fault", 64'(o_f), 64'd1);
        check("pf_paddr", o_pa, 64'd0);
        cyc(1, 64'h6000_0008, 2'd2, 0, 0, 0, 0);
        check("pf_no_walk", 64'(o_req), 64'd0);

        cyc(0, 0, 2'd0, 1, 0, 0, 0);
        for (int i = 0; i <= ENTRIES; i++) begin
            cyc(1, pg(32'h200 + i), 2'd0, 0, 0, 0, 0);
            cyc(0, 0, 2'd0, 0, 1, pg(32'h300 + i), 8'h0F);
        end
        cyc(1, pg(32'h200), 2'd0, 0, 0, 0, 0);
        check("wrap_first_miss", 64'(o_rv), 64'd0);
        for (int i = 1; i <= ENTRIES; i++) begin
            cyc(1, pg(32'h200 + i) | 64'h5, 2'd0, 0, 0, 0, 0);
            check("wrap_hit", o_pa, pg(32'h300 + i) | 64'h5);
        end
        cyc(0, 0, 2'd0, 0, 1, pg(32'h3F0), 8'h0F);
        cyc(1, pg(32'h201), 2'd0, 0, 0, 0, 0);
        check("wrap_rr_victim", 64'(o_rv), 64'd0);
        cyc(0, 0, 2'd0, 0, 1, pg(32'h3F1), 8'h0F);

        cyc(1, 64'h7000_0000, 2'd0, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 1, 0, 0, 0);
        cyc(0, 0, 2'd0, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 0, 1, 64'hB000_0000, 8'h0F);
        cyc(1, 64'h7000_0000, 2'd0, 0, 0, 0, 0);
        check("flush_walk_miss", 64'(o_rv), 64'd0);
        cyc(0, 0, 2'd0, 0, 0, 0, 0);
        check("flush_rewalk", o_ra, 64'h7000_0000);
        cyc(0, 0, 2'd0, 0, 1, 64'hB000_0000, 8'h0F);

        cyc(1, 64'h7100_0000, 2'd0, 0, 0, 0, 0);
        cyc(0, 0, 2'd0, 1, 1, 64'hC000_0000, 8'h0F);
        cyc(1, 64'h7100_0000, 2'd0, 0, 0, 0, 0);
        check("flush_same_cycle", 64'(o_rv), 64'd0);
        cyc(0, 0, 2'd0, 0, 1, 64'hC000_0000, 8'h0F);

        cyc(1, 64'h7200_0000, 2'd0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        check("arst_req_valid", 64'(mmu_req_valid), 64'd0);
        check("arst_req_addr", mmu_req_addr, 64'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1, 64'h4000_1234, 2'd0, 0, 0, 0, 0);
        check("arst_miss", 64'(o_rv), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [63:0] a, ra;
            logic [7:0]  rp;
            bit          lv, fl, rv;
            a = pg(32'h100 + $urandom_range(0, 11)) | 64'($urandom_range(0, 4095));
            lv = $urandom_range(0, 9) < 8;
            fl = $urandom_range(0, 49) == 0;
            rv = m_walk ? $urandom_range(0, 3) == 0 : $urandom_range(0, 30) == 0;
            ra = {$urandom, $urandom};
            rp = 8'($urandom) | ($urandom_range(0, 4) != 0 ? 8'h01 : 8'h00);
            cyc(lv, a, 2'($urandom), fl, rv, ra, rp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
